sd_image_server: RTL



---
 rtl/sd_image_pkg.sv | 19 +
 rtl/sd_image_server.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sd_image_pkg.sv
// Shared types and constants for the SDRAM-backed sector server.
package sd_image_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_SHIFT = 9;
    localparam int LBA_BITS     = 14;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_PUT,
        WR_ADDR,
        WR_LATCH,
        WR_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/sd_image_server.sv
// Sector-buffer responder: serves 512-byte reads/writes for drive 0 from a
// disk image held in SDRAM, one byte per SDRAM handshake.
import sd_image_pkg::*;

module sd_image_server #(
    parameter logic [22:0] IMG_BASE  = 23'h600000,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_valid,
    input  logic [31:0] img_size,
    input  logic [31:0] sd_lba,
    input  logic [1:0]  sd_rd,
    input  logic [1:0]  sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    input  logic [7:0]  sd_buff_din,
    output logic        sd_buff_wr,
    output logic [22:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ready
);

    state_t      state, state_nx;
    logic [8:0]  cnt;
    logic        cnt_inc;
    logic        armed;
    logic        in_range;
    logic [22:0] base;
    logic [7:0]  data;

    logic accept, rd_sel, drive0, lba_ok, last;

    // Sector size bits are irrelevant to the sector count.
    logic unused_size;
    assign unused_size = &{1'b0, img_size[SECTOR_SHIFT-1:0]};

    assign rd_sel = |sd_rd;
    assign accept = (state == IDLE) && armed && (rd_sel || (|sd_wr));
    // Reads win; the drive bit of the winning request decides backing.
    assign drive0 = rd_sel ? sd_rd[0] : sd_wr[0];
    assign lba_ok = img_valid && drive0
                 && (sd_lba < {{SECTOR_SHIFT{1'b0}}, img_size[31:SECTOR_SHIFT]})
                 && (sd_lba[31:LBA_BITS] == '0);
    assign last   = (cnt == 9'(SECTOR_BYTES - 1));

    assign sd_buff_addr = cnt;
    assign mem_addr     = base + {14'd0, cnt};
    assign sd_buff_dout = (state == RD_PUT && !in_range) ? FILL_BYTE : data;
    // Write data goes straight through in WR_LATCH so it is valid with mem_wr.
    assign mem_din      = (state == WR_LATCH) ? sd_buff_din : data;

    // Next-state and strobe decode.
    always_comb begin
        state_nx   = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        sd_buff_wr = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE:     if (accept) state_nx = rd_sel ? RD_REQ : WR_ADDR;
            RD_REQ: begin
                if (in_range) begin
                    mem_rd   = 1'b1;
                    state_nx = RD_WAIT;
                end else begin
                    state_nx = RD_PUT;
                end
            end
            RD_WAIT:  if (mem_ready) state_nx = RD_PUT;
            RD_PUT: begin
                sd_buff_wr = 1'b1;
                if (last) state_nx = DONE;
                else begin
                    cnt_inc  = 1'b1;
                    state_nx = in_range ? RD_REQ : RD_PUT;
                end
            end
            WR_ADDR:  state_nx = WR_LATCH;
            WR_LATCH: begin
                if (in_range) begin
                    mem_wr   = 1'b1;
                    state_nx = WR_WAIT;
                end else if (last) begin
                    state_nx = DONE;
                end else begin
                    cnt_inc  = 1'b1;
                    state_nx = WR_ADDR;
                end
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    if (last) state_nx = DONE;
                    else begin
                        cnt_inc  = 1'b1;
                        state_nx = WR_ADDR;
                    end
                end
            end
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // State, byte counter, accept-time address/range registers and data latch.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            armed    <= 1'b1;
            sd_ack   <= 1'b0;
            in_range <= 1'b0;
            base     <= '0;
            data     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt      <= '0;
                sd_ack   <= 1'b1;
                armed    <= 1'b0;
                in_range <= lba_ok;
                base     <= IMG_BASE + {sd_lba[LBA_BITS-1:0], {SECTOR_SHIFT{1'b0}}};
            end else begin
                if (cnt_inc) cnt <= cnt + 9'd1;
                if (!rd_sel && !(|sd_wr)) armed <= 1'b1;
            end
            if (state == DONE) sd_ack <= 1'b0;
            if (state == RD_WAIT && mem_ready) data <= mem_dout;
            if (state == WR_LATCH) data <= sd_buff_din;
        end
    end

endmodule
